// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache types: set/way geometry, PLRU update record and
// the replacement scheduler state encoding.
package wt_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC    = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);

  typedef struct packed {
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_WAY_WIDTH-1:0]    way;
  } repl_upd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } repl_sched_state_e;

endpackage

// File: rtl/wt_dcache_repl_fifo.sv
// Small synchronous queue of PLRU hit updates; a push into a full queue is
// accepted when the head pops in the same cycle.
module wt_dcache_repl_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clear_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  repl_upd_t data_i,
  output repl_upd_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  repl_upd_t       mem_q [FifoDepth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(FifoDepth));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/wt_dcache_repl_sched.sv
// PLRU update scheduler: round-robin hit arbitration into a FIFO, same-cycle
// miss pass-through and flush sequencing. WT_DCACHE_REPL_STATS_EN adds hit_drop_cnt_o.
//
// state | meaning
// IDLE  | normal traffic: arbitrate, enqueue, issue hits and misses
// FLUSH | one cycle: plru_flush_o, FIFO and RR pointer cleared, inputs ignored
// ACK   | one cycle: flush_ack_o, inputs ignored
module wt_dcache_repl_sched
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [NumPorts-1:0]                                hit_req_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]       hit_idx_i,
  input  logic [NumPorts-1:0][DCACHE_WAY_WIDTH-1:0]          hit_way_i,
  input  logic                                               miss_req_i,
  input  logic [DCACHE_CL_IDX_WIDTH-1:0]                     miss_idx_i,
  input  logic                                               flush_req_i,
  output logic                                               flush_ack_o,
  output logic                                               plru_hit_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                     plru_hit_idx_o,
  output logic [DCACHE_WAY_WIDTH-1:0]                        plru_hit_way_o,
  output logic                                               plru_miss_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                     plru_miss_idx_o,
`ifdef WT_DCACHE_REPL_STATS_EN
  output logic [15:0]                                        hit_drop_cnt_o,
`endif
  output logic                                               plru_flush_o
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  repl_sched_state_e state_q, state_d;
  logic [PtrW-1:0]   rr_q, rr_d, gnt_port, cand;
  logic              gnt_vld, idle, conflict, pop, push, accepted;
  logic              fifo_full, fifo_empty;
  repl_upd_t         head, push_data;
  int unsigned       p;

  assign idle     = (state_q == IDLE);
  assign conflict = miss_req_i & (miss_idx_i == head.idx);
  assign pop      = idle & ~fifo_empty & ~conflict;
  assign push     = idle & gnt_vld;
  assign accepted = push & (~fifo_full | pop);

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = '0;
    cand     = '0;
    p        = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      p    = (32'(rr_q) + i) % NumPorts;
      cand = PtrW'(p);
      if (!gnt_vld && hit_req_i[cand]) begin
        gnt_vld  = 1'b1;
        gnt_port = cand;
      end
    end
  end

  assign push_data = '{idx: hit_idx_i[gnt_port], way: hit_way_i[gnt_port]};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (push) rr_d = (gnt_port == PtrW'(NumPorts - 1)) ? '0 : gnt_port + 1'b1;
        if (flush_req_i) state_d = FLUSH;
      end
      FLUSH: begin
        rr_d    = '0;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  wt_dcache_repl_fifo #(
    .FifoDepth (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state_q == FLUSH),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are forced low while reset is held so the PLRU array sees nothing.
  assign plru_hit_o      = pop & ~rst_i;
  assign plru_hit_idx_o  = plru_hit_o ? head.idx : '0;
  assign plru_hit_way_o  = plru_hit_o ? head.way : '0;
  assign plru_miss_o     = miss_req_i & idle & ~rst_i;
  assign plru_miss_idx_o = miss_idx_i;
  assign plru_flush_o    = (state_q == FLUSH) & ~rst_i;
  assign flush_ack_o     = (state_q == ACK) & ~rst_i;

`ifdef WT_DCACHE_REPL_STATS_EN
  logic [3:0]  req_cnt, drop_num;
  logic [16:0] cnt_sum;
  logic [15:0] drop_cnt_q;

  always_comb begin
    req_cnt = '0;
    for (int unsigned i = 0; i < NumPorts; i++) req_cnt = req_cnt + 4'(hit_req_i[i]);
  end

  assign drop_num = idle ? (req_cnt - 4'(accepted)) : 4'd0;
  assign cnt_sum  = {1'b0, drop_cnt_q} + 17'(drop_num);

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign hit_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wt_dcache_repl_sched.sv
// Scoreboard bench for wt_dcache_repl_sched: expected hit updates are queued as
// requests are accepted and popped when the DUT issues them.
module tb_wt_dcache_repl_sched;
  import wt_cache_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 4;
  localparam int IW    = DCACHE_CL_IDX_WIDTH;
  localparam int WW    = DCACHE_WAY_WIDTH;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NP-1:0]           hit_req_i;
  logic [NP-1:0][IW-1:0]   hit_idx_i;
  logic [NP-1:0][WW-1:0]   hit_way_i;
  logic                    miss_req_i;
  logic [IW-1:0]           miss_idx_i;
  logic                    flush_req_i;
  logic                    flush_ack_o, plru_hit_o, plru_miss_o, plru_flush_o;
  logic [IW-1:0]           plru_hit_idx_o, plru_miss_idx_o;
  logic [WW-1:0]           plru_hit_way_o;
`ifdef WT_DCACHE_REPL_STATS_EN
  logic [15:0]             hit_drop_cnt_o;
`endif

  wt_dcache_repl_sched #(.NumPorts(NP), .FifoDepth(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .hit_req_i       (hit_req_i),
    .hit_idx_i       (hit_idx_i),
    .hit_way_i       (hit_way_i),
    .miss_req_i      (miss_req_i),
    .miss_idx_i      (miss_idx_i),
    .flush_req_i     (flush_req_i),
    .flush_ack_o     (flush_ack_o),
    .plru_hit_o      (plru_hit_o),
    .plru_hit_idx_o  (plru_hit_idx_o),
    .plru_hit_way_o  (plru_hit_way_o),
    .plru_miss_o     (plru_miss_o),
    .plru_miss_idx_o (plru_miss_idx_o),
`ifdef WT_DCACHE_REPL_STATS_EN
    .hit_drop_cnt_o  (hit_drop_cnt_o),
`endif
    .plru_flush_o    (plru_flush_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  repl_upd_t mq[$];
  int        m_rr    = 0;
  int        m_state = 0;
  int        m_drops = 0;
  int        base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [NP-1:0] req,
                      input logic [NP-1:0][IW-1:0] idx, input logic [NP-1:0][WW-1:0] way,
                      input logic miss, input logic [IW-1:0] midx, input logic flush);
    logic      idle, e_hit, gnt;
    int        pc, gp, q;
    repl_upd_t e;
    @(negedge clk_i);
    rst_i = rst; hit_req_i = req; hit_idx_i = idx; hit_way_i = way;
    miss_req_i = miss; miss_idx_i = midx; flush_req_i = flush;
    #1;
    if (rst) begin
      check("rst_hit", 32'(plru_hit_o), 0);
      check("rst_hit_idx", 32'(plru_hit_idx_o), 0);
      check("rst_miss", 32'(plru_miss_o), 0);
      check("rst_flush", 32'(plru_flush_o), 0);
      check("rst_ack", 32'(flush_ack_o), 0);
      mq.delete(); m_rr = 0; m_state = 0; m_drops = 0;
      return;
    end
    idle  = (m_state == 0);
    e_hit = idle && (mq.size() != 0) && !(miss && midx == mq[0].idx);
    check("hit_vld", 32'(plru_hit_o), 32'(e_hit));
    check("miss_vld", 32'(plru_miss_o), 32'(idle && miss));
    if (idle && miss) check("miss_idx", 32'(plru_miss_idx_o), 32'(midx));
    check("flush", 32'(plru_flush_o), 32'(m_state == 1));
    check("ack", 32'(flush_ack_o), 32'(m_state == 2));
`ifdef WT_DCACHE_REPL_STATS_EN
    check("drop_cnt", 32'(hit_drop_cnt_o), 32'(m_drops));
`endif
    if (plru_hit_o) begin
      if (mq.size() == 0) check("hit_unexpected", 1, 0);
      else begin
        e = mq.pop_front();
        check("hit_idx", 32'(plru_hit_idx_o), 32'(e.idx));
        check("hit_way", 32'(plru_hit_way_o), 32'(e.way));
      end
    end
    case (m_state)
      0: begin
        pc = 0;
        for (int i = 0; i < NP; i++) pc += int'(req[i]);
        gnt = 1'b0; gp = 0;
        for (int i = 0; i < NP; i++) begin
          q = (m_rr + i) % NP;
          if (!gnt && req[q]) begin gnt = 1'b1; gp = q; end
        end
        if (gnt) begin
          m_rr = (gp + 1) % NP;
          if (mq.size() < DEPTH) begin
            mq.push_back('{idx: idx[gp], way: way[gp]});
            pc--;
          end
        end
        m_drops = (m_drops + pc > 65535) ? 65535 : m_drops + pc;
        if (flush) m_state = 1;
      end
      1: begin mq.delete(); m_rr = 0; m_state = 2; end
      default: m_state = 0;
    endcase
  endtask

  task automatic quiet(input logic miss, input logic [IW-1:0] midx, input logic flush);
    step(1'b0, '0, '0, '0, miss, midx, flush);
  endtask

  task automatic hit0(input logic [IW-1:0] idx, input logic [WW-1:0] way,
                      input logic miss, input logic [IW-1:0] midx);
    step(1'b0, 3'b001, {8'd0, 8'd0, idx}, {2'd0, 2'd0, way}, miss, midx, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; hit_req_i = '0; hit_idx_i = '0; hit_way_i = '0;
    miss_req_i = 1'b0; miss_idx_i = '0; flush_req_i = 1'b0;
    step(1'b1, '0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b1, '0, '0, '0, 1'b0, '0, 1'b0);
    quiet(1'b0, '0, 1'b0);
`ifdef WT_DCACHE_REPL_STATS_EN
    check("cnt_after_reset", 32'(hit_drop_cnt_o), 0);
`endif

    // single hit on port 0: out next cycle, queue empty after
    hit0(8'd5, 2'd2, 1'b0, '0);
    quiet(1'b0, '0, 1'b0);
    check("single_hit_vld", 32'(plru_hit_o), 1);
    check("single_hit_idx", 32'(plru_hit_idx_o), 5);
    check("single_hit_way", 32'(plru_hit_way_o), 2);
    quiet(1'b0, '0, 1'b0);
    check("single_empty", 32'(plru_hit_o), 0);

    // three ports twice from RR pointer 0: grants port 0 then port 1
    step(1'b1, '0, '0, '0, 1'b0, '0, 1'b0);
    quiet(1'b0, '0, 1'b0);
`ifdef WT_DCACHE_REPL_STATS_EN
    base = int'(hit_drop_cnt_o);
`endif
    step(1'b0, 3'b111, {8'd12, 8'd11, 8'd10}, {2'd3, 2'd2, 2'd1}, 1'b0, '0, 1'b0);
    step(1'b0, 3'b111, {8'd12, 8'd11, 8'd10}, {2'd3, 2'd2, 2'd1}, 1'b0, '0, 1'b0);
    check("rr_first_idx", 32'(plru_hit_idx_o), 10);
    quiet(1'b0, '0, 1'b0);
    check("rr_second_idx", 32'(plru_hit_idx_o), 11);
`ifdef WT_DCACHE_REPL_STATS_EN
    check("rr_drops", 32'(int'(hit_drop_cnt_o) - base), 4);
`endif
    quiet(1'b0, '0, 1'b0);

    // miss to the head's set defers the hit one cycle
    hit0(8'd9, 2'd1, 1'b0, '0);
    quiet(1'b1, 8'd9, 1'b0);
    check("conf_hit", 32'(plru_hit_o), 0);
    check("conf_miss", 32'(plru_miss_o), 1);
    quiet(1'b0, '0, 1'b0);
    check("conf_retry", 32'(plru_hit_o), 1);
    check("conf_retry_idx", 32'(plru_hit_idx_o), 9);

    // miss to a different set: both issue together
    hit0(8'd9, 2'd3, 1'b0, '0);
    quiet(1'b1, 8'd3, 1'b0);
    check("noconf_hit", 32'(plru_hit_o), 1);
    check("noconf_miss", 32'(plru_miss_o), 1);
    quiet(1'b0, '0, 1'b0);

    // fill the queue behind a blocked head, fifth request dropped
`ifdef WT_DCACHE_REPL_STATS_EN
    base = int'(hit_drop_cnt_o);
`endif
    for (int i = 0; i < 5; i++) hit0(8'(20 + i), 2'(i), 1'b1, 8'd20);
    quiet(1'b1, 8'd20, 1'b0);
`ifdef WT_DCACHE_REPL_STATS_EN
    check("full_drop", 32'(int'(hit_drop_cnt_o) - base), 1);
`endif
    for (int i = 0; i < 5; i++) quiet(1'b0, '0, 1'b0);
    check("full_drained", 32'(mq.size()), 0);

    // flush with three entries queued
    for (int i = 0; i < 3; i++) hit0(8'(30 + i), 2'd0, 1'b1, 8'd30);
    quiet(1'b1, 8'd30, 1'b1);
    step(1'b0, 3'b011, {8'd0, 8'd7, 8'd30}, '0, 1'b1, 8'd1, 1'b1);
    check("flush_pulse", 32'(plru_flush_o), 1);
    check("flush_no_hit", 32'(plru_hit_o), 0);
    check("flush_no_miss", 32'(plru_miss_o), 0);
    step(1'b0, 3'b001, {8'd0, 8'd0, 8'd31}, '0, 1'b1, 8'd31, 1'b1);
    check("flush_ack", 32'(flush_ack_o), 1);
    step(1'b0, 3'b010, {8'd0, 8'd40, 8'd0}, {2'd0, 2'd3, 2'd0}, 1'b0, '0, 1'b0);
    check("flush_empty", 32'(plru_hit_o), 0);
    quiet(1'b0, '0, 1'b0);
    check("post_flush_hit", 32'(plru_hit_o), 1);
    check("post_flush_idx", 32'(plru_hit_idx_o), 40);
    check("post_flush_way", 32'(plru_hit_way_o), 3);

    // reset during FLUSH: back to IDLE, no ack
    quiet(1'b0, '0, 1'b1);
    step(1'b1, '0, '0, '0, 1'b0, '0, 1'b0);
    quiet(1'b0, '0, 1'b0);
    check("rst_no_ack", 32'(flush_ack_o), 0);
    quiet(1'b0, '0, 1'b0);

    // random traffic with narrow index range to provoke conflicts
    for (int n = 0; n < 400; n++) begin
      step(1'b0, NP'($urandom_range(0, 7)),
           {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
           {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end
    for (int n = 0; n < 8; n++) quiet(1'b0, '0, 1'b0);
    check("final_drained", 32'(mq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
